// File: rtl/aes_encrypt_iter_if.sv
// Block-encrypt handshake bundle for aes_encrypt_iter: request side (start,
// plaintext, key schedule) and result side (cipher, busy, done).
// Bit ordering follows FIPS-197: bit 0 is the MSB of byte 0.
interface aes_encrypt_iter_if #(
    parameter int unsigned nr = 10
);
    logic                       start;
    logic [0:127]               plaintext;
    logic [0:128*(nr+1)-1]      keySchedule;
    logic [0:127]               cipher;
    logic                       busy;
    logic                       done;

    modport master (
        output start, plaintext, keySchedule,
        input  cipher, busy, done
    );

    modport slave (
        input  start, plaintext, keySchedule,
        output cipher, busy, done
    );
endinterface

// File: rtl/aes_encrypt_iter.sv
// Iterative AES block encryptor: one round per clock from a precomputed
// round-key schedule (round key r at keySchedule[128*r +: 128]).
// Optional build macro AES_ENC_TWO_CYCLE_ROUND_EN splits every round over two
// edges (SubBytes+ShiftRows, then MixColumns+AddRoundKey).
module aes_encrypt_iter #(
    parameter int unsigned nk = 4,
    parameter int unsigned nr = 10
) (
    input  logic              clk,
    input  logic              reset,
    aes_encrypt_iter_if.slave bus
);

    localparam int unsigned RND_W = 5;
    localparam logic [RND_W-1:0] NR_CNT = RND_W'(nr);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ROUND = 2'd1;
    localparam logic [1:0] FINAL = 2'd2;

    // Key length and round count must describe the same AES variant.
    if (nr != nk + 6) begin : g_cfg_check
        $error("aes_encrypt_iter: nr must equal nk+6");
    end

    localparam logic [0:2047] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[{b, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // SubBytes followed by ShiftRows (row r rotated left by r columns).
    function automatic logic [0:127] sub_shift(input logic [0:127] s);
        logic [0:127] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[8*(4*c+r) +: 8] = sbox(s[8*(4*((c+r)%4)+r) +: 8]);
            end
        end
        return o;
    endfunction

    function automatic logic [0:127] mix_cols(input logic [0:127] s);
        logic [0:127] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[32*c      +: 8];
            a1 = s[32*c + 8  +: 8];
            a2 = s[32*c + 16 +: 8];
            a3 = s[32*c + 24 +: 8];
            o[32*c      +: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[32*c + 8  +: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[32*c + 16 +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[32*c + 24 +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

    logic [1:0]       fsm_q, fsm_d;
    logic [RND_W-1:0] round_q, round_d;
    logic [0:127]     state_q, state_d;
    logic [0:127]     cipher_q, cipher_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
`ifdef AES_ENC_TWO_CYCLE_ROUND_EN
    logic             phase_q, phase_d;
`endif
    logic [0:127]     sb_sr;
    logic [0:127]     rk;

    // Round datapath operands: substituted/shifted state and current round key.
    always_comb begin
        sb_sr = sub_shift(state_q);
        rk    = bus.keySchedule[{round_q, 7'd0} +: 128];
    end

    // Next-state and next-register computation for the round sequencer.
    always_comb begin
        fsm_d    = fsm_q;
        round_d  = round_q;
        state_d  = state_q;
        cipher_d = cipher_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
`ifdef AES_ENC_TWO_CYCLE_ROUND_EN
        phase_d  = phase_q;
`endif
        case (fsm_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = bus.plaintext ^ bus.keySchedule[0:127];
                    round_d = RND_W'(1);
                    busy_d  = 1'b1;
                    fsm_d   = (nr == 1) ? FINAL : ROUND;
                end
            end
            ROUND: begin
`ifdef AES_ENC_TWO_CYCLE_ROUND_EN
                if (!phase_q) begin
                    state_d = sb_sr;
                    phase_d = 1'b1;
                end else begin
                    state_d = mix_cols(state_q) ^ rk;
                    phase_d = 1'b0;
                    round_d = round_q + RND_W'(1);
                    if (round_d == NR_CNT) fsm_d = FINAL;
                end
`else
                state_d = mix_cols(sb_sr) ^ rk;
                round_d = round_q + RND_W'(1);
                if (round_d == NR_CNT) fsm_d = FINAL;
`endif
            end
            FINAL: begin
`ifdef AES_ENC_TWO_CYCLE_ROUND_EN
                if (!phase_q) begin
                    state_d = sb_sr;
                    phase_d = 1'b1;
                end else begin
                    cipher_d = state_q ^ rk;
                    phase_d  = 1'b0;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    fsm_d    = IDLE;
                end
`else
                cipher_d = sb_sr ^ rk;
                done_d   = 1'b1;
                busy_d   = 1'b0;
                fsm_d    = IDLE;
`endif
            end
            default: begin
                fsm_d  = IDLE;
                busy_d = 1'b0;
            end
        endcase
    end

    // State and output registers; synchronous reset abandons any block in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            fsm_q    <= IDLE;
            round_q  <= '0;
            state_q  <= '0;
            cipher_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef AES_ENC_TWO_CYCLE_ROUND_EN
            phase_q  <= 1'b0;
`endif
        end else begin
            fsm_q    <= fsm_d;
            round_q  <= round_d;
            state_q  <= state_d;
            cipher_q <= cipher_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef AES_ENC_TWO_CYCLE_ROUND_EN
            phase_q  <= phase_d;
`endif
        end
    end

    assign bus.cipher = cipher_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;

endmodule

// File: tb/tb_aes_encrypt_iter.sv
// Testbench for aes_encrypt_iter: FIPS-197 known answers, handshake corner
// cases and random blocks against a byte-array AES reference model.
module tb_aes_encrypt_iter;

    localparam int unsigned NR = 10;
    localparam int unsigned KS_W = 128*(NR+1);
`ifdef AES_ENC_TWO_CYCLE_ROUND_EN
    localparam int LAT = 2*NR + 1;
`else
    localparam int LAT = NR + 1;
`endif

    logic clk;
    logic reset;

    aes_encrypt_iter_if #(.nr(NR)) bus ();

    aes_encrypt_iter #(.nk(4), .nr(NR)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] sb [256];

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p ^= x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    // S-box from its definition: multiplicative inverse then affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [0:KS_W-1] expand_key(input logic [0:127] key);
        logic [31:0] w [4*(NR+1)];
        logic [31:0] t;
        logic [7:0]  rcon;
        logic [0:KS_W-1] ks;
        rcon = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[32*i +: 32];
        for (int i = 4; i < 4*(NR+1); i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rcon, 24'h0};
                rcon = gmul(rcon, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int i = 0; i < 4*(NR+1); i++) ks[32*i +: 32] = w[i];
        return ks;
    endfunction

    function automatic logic [0:127] ref_encrypt(input logic [0:127] pt, input logic [0:KS_W-1] ks);
        logic [7:0] s [16];
        logic [7:0] t [16];
        logic [0:127] out;
        for (int i = 0; i < 16; i++) s[i] = pt[8*i +: 8] ^ ks[8*i +: 8];
        for (int rd = 1; rd <= NR; rd++) begin
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    t[4*c+r] = sb[s[4*((c+r)%4)+r]];
            for (int c = 0; c < 4; c++) begin
                if (rd < NR) begin
                    s[4*c]   = gmul(t[4*c],8'h02) ^ gmul(t[4*c+1],8'h03) ^ t[4*c+2] ^ t[4*c+3];
                    s[4*c+1] = t[4*c] ^ gmul(t[4*c+1],8'h02) ^ gmul(t[4*c+2],8'h03) ^ t[4*c+3];
                    s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(t[4*c+2],8'h02) ^ gmul(t[4*c+3],8'h03);
                    s[4*c+3] = gmul(t[4*c],8'h03) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(t[4*c+3],8'h02);
                end else begin
                    for (int r = 0; r < 4; r++) s[4*c+r] = t[4*c+r];
                end
            end
            for (int i = 0; i < 16; i++) s[i] ^= ks[128*rd + 8*i +: 8];
        end
        for (int i = 0; i < 16; i++) out[8*i +: 8] = s[i];
        return out;
    endfunction

    // Runs until done (E0 already taken); optionally re-pulses start at a given edge count.
    task automatic wait_done(input int poke_edge, output int edges);
        logic [0:127] pt_hold;
        edges = 1;
        while (!bus.done && edges < 80) begin
            chk("busy_during_run", 128'(bus.busy), 128'(1));
            if (edges == poke_edge) begin
                pt_hold = bus.plaintext;
                bus.start = 1'b1;
                bus.plaintext = '1;
                step();
                bus.start = 1'b0;
                bus.plaintext = pt_hold;
            end else begin
                step();
            end
            edges++;
        end
        if (!bus.done) chk("done_timeout", 128'(bus.done), 128'(1));
        else chk("busy_at_done", 128'(bus.busy), 128'(0));
    endtask

    task automatic run_block(input string tag, input logic [0:127] pt, input logic [0:KS_W-1] ks,
                             input logic [0:127] exp_ct, input int poke_edge);
        int edges;
        bus.start = 1'b1;
        bus.plaintext = pt;
        bus.keySchedule = ks;
        step();
        bus.start = 1'b0;
        bus.plaintext = ~pt;
        wait_done(poke_edge, edges);
        chk({tag, "_latency"}, 128'(edges), 128'(LAT));
        chk({tag, "_cipher"}, bus.cipher, exp_ct);
    endtask

    logic [0:127] key_c1, pt_c1, ct_c1, key_b, pt_b, ct_b;
    logic [0:KS_W-1] ks_c1, ks_b, ks_r;
    logic [0:127] key_r, pt_r;
    int dones;

    initial begin
        key_c1 = 128'h000102030405060708090a0b0c0d0e0f;
        pt_c1  = 128'h00112233445566778899aabbccddeeff;
        ct_c1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        key_b  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        pt_b   = 128'h3243f6a8885a308d313198a2e0370734;
        ct_b   = 128'h3925841d02dc09fbdc118597196a0b32;
        bus.start = 1'b0;
        bus.plaintext = '0;
        bus.keySchedule = '0;
        reset = 1'b1;
        build_sbox();
        ks_c1 = expand_key(key_c1);
        ks_b  = expand_key(key_b);
        step();
        step();
        reset = 1'b0;

        chk("reset_cipher", bus.cipher, 128'h0);
        chk("reset_busy", 128'(bus.busy), 128'(0));
        chk("reset_done", 128'(bus.done), 128'(0));
        chk("model_c1", ref_encrypt(pt_c1, ks_c1), ct_c1);
        step();

        // FIPS-197 C.1 with a one-cycle done check
        run_block("c1", pt_c1, ks_c1, ct_c1, 0);
        step();
        chk("done_one_cycle", 128'(bus.done), 128'(0));
        chk("cipher_holds", bus.cipher, ct_c1);
        step();

        // FIPS-197 App. B, including the post-E0 state
        bus.start = 1'b1;
        bus.plaintext = pt_b;
        bus.keySchedule = ks_b;
        step();
        bus.start = 1'b0;
        chk("appb_state_e0", dut.state_q, 128'h193de3bea0f4e22b9ac68d2ae9f84808);
        begin
            int edges;
            wait_done(0, edges);
            chk("appb_latency", 128'(edges), 128'(LAT));
        end
        chk("appb_cipher", bus.cipher, ct_b);
        step();

        // Back-to-back: second block accepted at the edge that follows done
        run_block("b2b_first", pt_c1, ks_c1, ct_c1, 0);
        run_block("b2b_second", pt_b, ks_b, ct_b, 0);
        step();

        // start re-pulsed while busy is ignored
        run_block("busy_ignore", pt_c1, ks_c1, ct_c1, 4);
        dones = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (bus.done) dones++;
        end
        chk("busy_ignore_no_rerun", 128'(dones), 128'(0));
        chk("busy_ignore_idle", 128'(bus.busy), 128'(0));

        // Reset at E0+5 abandons the block
        bus.start = 1'b1;
        bus.plaintext = pt_b;
        bus.keySchedule = ks_b;
        step();
        bus.start = 1'b0;
        for (int i = 0; i < 4; i++) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("midrst_cipher", bus.cipher, 128'h0);
        chk("midrst_busy", 128'(bus.busy), 128'(0));
        chk("midrst_done", 128'(bus.done), 128'(0));
        dones = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (bus.done) dones++;
        end
        chk("midrst_no_done", 128'(dones), 128'(0));
        chk("midrst_cipher_held", bus.cipher, 128'h0);
        run_block("after_rst", pt_c1, ks_c1, ct_c1, 0);

        // Random keys and blocks, streamed back-to-back
        for (int n = 0; n < 16; n++) begin
            key_r = {$urandom, $urandom, $urandom, $urandom};
            pt_r  = {$urandom, $urandom, $urandom, $urandom};
            ks_r  = expand_key(key_r);
            run_block("rand", pt_r, ks_r, ref_encrypt(pt_r, ks_r), 0);
            if (n % 4 == 3) step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
